button_scheduler: RTL and testbench

- Front-end controller for a bank of NBTN debounced push-buttons.
- Generates the shared sample timebase for all debouncers and turns each debounced level into press and auto-repeat events.
- Queues one pending event per button and issues them one at a time to the command consumer over a valid/ready handshake, with round-robin arbitration.
- Sits between the per-button debounce FSMs and the application control logic.

---
 rtl/button_scheduler_pkg.sv | 19 +
 rtl/button_scheduler_if.sv | 13 +
 rtl/btn_tracker.sv | 63 ++++++
 rtl/button_scheduler.sv | 95 +++++++++
 tb/tb_button_scheduler.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/button_scheduler_pkg.sv
// button_scheduler_pkg: shared tracker state encoding and round-robin pick helper
// Contents: trk_state_t (IDLE/HELD/REPEAT), rr_pick(req, ptr, n) -> first set index after ptr, mod n
package button_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HELD   = 2'b01,
        REPEAT = 2'b10
    } trk_state_t;

    // Scans downward so the last hit written is the closest one after ptr.
    function automatic int unsigned rr_pick(input logic [31:0] req, input int unsigned ptr, input int unsigned n);
        rr_pick = ptr;
        for (int unsigned k = n; k > 0; k--)
            if (req[5'((ptr + k) % n)])
                rr_pick = (ptr + k) % n;
    endfunction

endpackage

// File: rtl/button_scheduler_if.sv
// button_scheduler_if: command valid/ready channel from scheduler to consumer
// Signals: valid (command present), ready (consumer accepts), id (button index), rpt (0 press, 1 auto-repeat)
interface button_scheduler_if #(
    parameter int unsigned IDW = 2
) ();
    logic           valid;
    logic           ready;
    logic [IDW-1:0] id;
    logic           rpt;

    modport master (output valid, output id, output rpt, input ready);
    modport slave  (input valid, input id, input rpt, output ready);
endinterface

// File: rtl/btn_tracker.sv
// btn_tracker: turns one debounced level into press and auto-repeat event pulses
// Ports: clk, rst_n (async active-low), i_level (debounced level), i_sample_tick (timebase pulse),
//        o_event_pulse (one-cycle event), o_event_repeat (event is an auto-repeat)
module btn_tracker
    import button_scheduler_pkg::*;
#(
    parameter int unsigned REPEAT_TICKS = 12,
    parameter int unsigned RATE_TICKS   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    input  logic i_sample_tick,
    output logic o_event_pulse,
    output logic o_event_repeat
);
    localparam int unsigned HMAX = (REPEAT_TICKS > RATE_TICKS) ? REPEAT_TICKS : RATE_TICKS;
    localparam int unsigned HW   = $clog2(HMAX + 1);

    trk_state_t    r_state, w_next;
    logic          r_prev;
    logic [HW-1:0] r_hcnt, w_hcnt;
    logic          w_rise, w_hit;

    assign w_rise = i_level && !r_prev;
    // HELD waits for the initial delay, REPEAT for the repeat period.
    assign w_hit  = i_sample_tick &&
                    (r_hcnt == ((r_state == HELD) ? HW'(REPEAT_TICKS - 1) : HW'(RATE_TICKS - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_prev  <= 1'b0;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_prev  <= i_level;
            r_hcnt  <= w_hcnt;
        end
    end

    always_comb begin
        w_next = r_state;
        w_hcnt = r_hcnt;
        if (r_state == IDLE) begin
            if (w_rise) begin
                w_next = HELD;
                w_hcnt = '0;
            end
        end else if (!i_level) begin
            w_next = IDLE;
        end else if (i_sample_tick) begin
            w_next = w_hit ? REPEAT : r_state;
            w_hcnt = w_hit ? '0 : r_hcnt + 1'b1;
        end
    end

    // A low level beats a tick in the same cycle: no event on release.
    always_comb begin
        o_event_pulse  = (r_state == IDLE) ? w_rise : (i_level && w_hit);
        o_event_repeat = o_event_pulse && (r_state != IDLE);
    end
endmodule

// File: rtl/button_scheduler.sv
// button_scheduler: sample timebase, per-button event trackers, pending store and round-robin command issue
// Ports: clk, rst_n (async active-low), i_enable (permit grants), i_db_level (debounced levels),
//        o_sample_tick (timebase pulse), o_pending (queued events), o_overrun (sticky event loss),
//        cmd (master side of the valid/ready command channel)
module button_scheduler
    import button_scheduler_pkg::*;
#(
    parameter int unsigned NBTN         = 4,
    parameter int unsigned IDW          = 2,
    parameter int unsigned TICK_BITS    = 21,
    parameter int unsigned REPEAT_TICKS = 12,
    parameter int unsigned RATE_TICKS   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic [NBTN-1:0]   i_db_level,
    output logic              o_sample_tick,
    output logic [NBTN-1:0]   o_pending,
    output logic              o_overrun,
    button_scheduler_if.master cmd
);
    logic [TICK_BITS-1:0] r_cnt;
    logic                 r_tick;
    logic [NBTN-1:0]      r_pend, r_rep, w_ev, w_evr, w_gsel;
    logic                 r_ovr, r_valid, r_rpt;
    logic [IDW-1:0]       r_id, r_rr, w_gidx;
    logic                 w_free, w_grant;

    // Tick is registered off the all-ones count so it is high while the counter reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= &r_cnt;
        end
    end

    for (genvar g = 0; g < NBTN; g++) begin : g_trk
        btn_tracker #(
            .REPEAT_TICKS (REPEAT_TICKS),
            .RATE_TICKS   (RATE_TICKS)
        ) u_trk (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_level        (i_db_level[g]),
            .i_sample_tick  (r_tick),
            .o_event_pulse  (w_ev[g]),
            .o_event_repeat (w_evr[g])
        );
    end

    assign w_free  = !r_valid || cmd.ready;
    assign w_grant = w_free && i_enable && |r_pend;
    assign w_gidx  = IDW'(rr_pick(32'(r_pend), 32'(r_rr), NBTN));
    assign w_gsel  = w_grant ? (NBTN'(1) << w_gidx) : '0;

    // A new event merges its repeat flag only into an entry that survives this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_rep  <= '0;
            r_ovr  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_gsel) | w_ev;
            r_rep  <= (w_ev & (w_evr | (r_rep & r_pend & ~w_gsel))) | (~w_ev & r_rep);
            r_ovr  <= r_ovr | (|(w_ev & r_pend & ~w_gsel));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_rpt   <= 1'b0;
            r_rr    <= '0;
        end else if (w_grant) begin
            r_valid <= 1'b1;
            r_id    <= w_gidx;
            r_rpt   <= r_rep[w_gidx];
            r_rr    <= w_gidx;
        end else if (w_free) begin
            r_valid <= 1'b0;
        end
    end

    assign cmd.valid     = r_valid;
    assign cmd.id        = r_id;
    assign cmd.rpt       = r_rpt;
    assign o_sample_tick = r_tick;
    assign o_pending     = r_pend;
    assign o_overrun     = r_ovr;
endmodule

// File: tb/tb_button_scheduler.sv
// tb_button_scheduler: randomized bench for button_scheduler against a behavioural reference model
module tb_button_scheduler;
    localparam int NB = 4;
    localparam int IW = 2;
    localparam int TB = 4;
    localparam int RT = 2;
    localparam int RA = 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic [NB-1:0] lvl   = '0;
    logic          tick, ovr;
    logic [NB-1:0] pend;

    button_scheduler_if #(.IDW(IW)) bus ();

    button_scheduler #(
        .NBTN(NB), .IDW(IW), .TICK_BITS(TB), .REPEAT_TICKS(RT), .RATE_TICKS(RA)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (en),
        .i_db_level    (lvl),
        .o_sample_tick (tick),
        .o_pending     (pend),
        .o_overrun     (ovr),
        .cmd           (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: what the outputs should read after the latest clock edge.
    int            n;
    int            k [NB];
    logic [NB-1:0] mprev, mp, mr;
    logic          movr, mvalid, mrpt;
    int            mid, mrr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0; mprev = '0; mp = '0; mr = '0;
        movr = 1'b0; mvalid = 1'b0; mrpt = 1'b0; mid = 0; mrr = 0;
        for (int i = 0; i < NB; i++) k[i] = 0;
    endtask

    function automatic logic tick_now();
        return (n > 0) && (n % (1 << TB) == 0);
    endfunction

    // Events from hold time: a press on the rising edge, then repeats on held ticks
    // number RT, RT+RA, RT+2*RA, ... counted since the press.
    task automatic step();
        logic [NB-1:0] ev, evr;
        logic          t, free;
        int            gi, idx;
        t = tick_now();
        ev = '0; evr = '0;
        for (int i = 0; i < NB; i++) begin
            if (lvl[i] && !mprev[i]) begin
                ev[i] = 1'b1; k[i] = 0;
            end else if (lvl[i] && t) begin
                k[i]++;
                if (k[i] >= RT && (k[i] - RT) % RA == 0) begin
                    ev[i] = 1'b1; evr[i] = 1'b1;
                end
            end
        end
        mprev = lvl;
        free = !mvalid || bus.ready;
        gi = -1;
        if (free && en && mp != '0)
            for (int s = 1; s <= NB; s++) begin
                idx = (mrr + s) % NB;
                if (gi < 0 && mp[idx]) gi = idx;
            end
        if (gi >= 0) begin
            mvalid = 1'b1; mid = gi; mrpt = mr[gi]; mrr = gi;
        end else if (free) begin
            mvalid = 1'b0;
        end
        for (int i = 0; i < NB; i++) begin
            if (ev[i]) begin
                if (mp[i] && i != gi) begin
                    movr = 1'b1; mr[i] = mr[i] | evr[i];
                end else begin
                    mr[i] = evr[i];
                end
                mp[i] = 1'b1;
            end else if (i == gi) begin
                mp[i] = 1'b0;
            end
        end
        n++;
    endtask

    task automatic compare();
        check("sample_tick", 32'(tick), 32'(tick_now()));
        check("pending", 32'(pend), 32'(mp));
        check("overrun", 32'(ovr), 32'(movr));
        check("cmd_valid", 32'(bus.valid), 32'(mvalid));
        if (mvalid) begin
            check("cmd_id", 32'(bus.id), 32'(mid));
            check("cmd_repeat", 32'(bus.rpt), 32'(mrpt));
        end
    endtask

    task automatic cyc(input logic [NB-1:0] l, input logic e, input logic r);
        lvl = l; en = e; bus.ready = r;
        step();
        @(negedge clk);
        compare();
    endtask

    task automatic rnd_cyc(input int pr, input int pe, input int pt);
        logic [NB-1:0] l;
        l = lvl;
        for (int i = 0; i < NB; i++)
            if ($urandom_range(pt - 1) == 0) l[i] = ~l[i];
        cyc(l, 1'($urandom_range(99) < pe), 1'($urandom_range(99) < pr));
    endtask

    initial begin
        int waited;
        bus.ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare();
        rst_n = 1'b1;
        repeat (20) cyc(4'b0000, 1'b1, 1'b1);
        repeat (6) cyc(4'b1111, 1'b1, 1'b1);
        repeat (4) cyc(4'b0000, 1'b1, 1'b1);
        repeat (3) cyc(4'b0010, 1'b1, 1'b0);
        repeat (2) cyc(4'b0000, 1'b1, 1'b0);
        repeat (3) cyc(4'b0010, 1'b1, 1'b0);
        repeat (2) cyc(4'b0000, 1'b1, 1'b0);
        repeat (4) cyc(4'b0000, 1'b1, 1'b1);
        repeat (70) cyc(4'b0100, 1'b1, 1'b1);
        repeat (5) cyc(4'b0000, 1'b1, 1'b1);
        for (int seg = 0; seg < 4; seg++)
            for (int c = 0; c < 1500; c++)
                case (seg)
                    0: rnd_cyc(100, 100, 40);
                    1: rnd_cyc(20, 100, 15);
                    2: rnd_cyc(70, 60, 25);
                    default: rnd_cyc(90, 100, 60);
                endcase
        waited = 0;
        while (!(mvalid && bus.valid) && waited < 200) begin
            cyc((waited % 2) ? 4'b1111 : 4'b0000, 1'b1, 1'b0);
            waited++;
        end
        check("reset_setup_valid", 32'(bus.valid), 32'd1);
        #2 rst_n = 1'b0;
        lvl = '0;
        #1;
        check("async_cmd_valid", 32'(bus.valid), 32'd0);
        check("async_pending", 32'(pend), 32'd0);
        check("async_overrun", 32'(ovr), 32'd0);
        model_reset();
        @(negedge clk);
        compare();
        rst_n = 1'b1;
        repeat (20) cyc(4'b0000, 1'b1, 1'b1);
        repeat (300) rnd_cyc(80, 90, 30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
